// File: rtl/hdc_action_scheduler.sv
// Sequencer for the HDC Q-learning action-selection datapath: clear, warm up generators,
// stream chunk addresses, drain the pipeline, serial signed argmax. Optional: HDC_SCHED_EXPLORE_EN.
module hdc_action_scheduler #(
  parameter int LFSR_ACTIONS = 4,
  parameter int ACC_WIDTH    = 22,
  parameter int ADDR_WIDTH   = 11,
  parameter int NUM_CHUNKS   = 64,
  parameter int PIPE_DEPTH   = 3,
  parameter int GEN_WARMUP   = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  output logic                                     proj_init,
  output logic                                     act_init,
  output logic [ADDR_WIDTH-2:0]                    ram_ptr,
  output logic [PIPE_DEPTH-1:0]                    stage_en,
  output logic                                     acc_clr,
  output logic                                     acc_en,
  input  logic [LFSR_ACTIONS-1:0][ACC_WIDTH-1:0]   acc_in,
`ifdef HDC_SCHED_EXPLORE_EN
  input  logic [7:0]                               explore_rnd,
  input  logic [7:0]                               epsilon,
  output logic                                     act_explored,
`endif
  output logic [$clog2(LFSR_ACTIONS)-1:0]          act_idx,
  output logic signed [ACC_WIDTH-1:0]              act_value,
  output logic                                     act_valid,
  input  logic                                     act_ready,
  output logic                                     busy
);

  localparam int IDX_W = $clog2(LFSR_ACTIONS);
  localparam int PTR_W = ADDR_WIDTH - 1;
  localparam int CNT_W = 16;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CHUNKS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, WARMUP, STREAM, DRAIN, ARGMAX, OUTPUT
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]            cnt;
  logic [PIPE_DEPTH:0]         vpipe;
  logic [IDX_W-1:0]            best_idx;
  logic signed [ACC_WIDTH-1:0] best_val;
  logic [IDX_W-1:0]            cmp_idx;
  logic signed [ACC_WIDTH-1:0] cmp_val;
  logic [IDX_W-1:0]            sel_idx;
  logic signed [ACC_WIDTH-1:0] sel_val;
  logic                        sel_explored;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    proj_init  = 1'b0;
    act_init   = 1'b0;
    acc_clr    = 1'b0;
    act_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = CLEAR;
      end
      CLEAR: begin
        acc_clr    = 1'b1;
        proj_init  = 1'b1;
        act_init   = 1'b1;
        state_next = WARMUP;
      end
      WARMUP: if (cnt == CNT_W'(GEN_WARMUP - 1))   state_next = STREAM;
      STREAM: if (ram_ptr == PTR_LAST)             state_next = DRAIN;
      DRAIN:  if (cnt == CNT_W'(PIPE_DEPTH))       state_next = ARGMAX;
      ARGMAX: if (cnt == CNT_W'(LFSR_ACTIONS - 2)) state_next = OUTPUT;
      OUTPUT: begin
        act_valid = 1'b1;
        if (act_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign stage_en  = vpipe[PIPE_DEPTH-1:0];
  assign acc_en    = vpipe[PIPE_DEPTH];
  assign act_idx   = best_idx;
  assign act_value = best_val;

  // ARGMAX cycle n compares index n+1; ties keep the earlier (lower) index.
  always_comb begin
    cmp_idx      = IDX_W'(cnt + CNT_W'(1));
    cmp_val      = $signed(acc_in[cmp_idx]);
    sel_idx      = best_idx;
    sel_val      = best_val;
    sel_explored = 1'b0;
    if (cmp_val > best_val) begin
      sel_idx = cmp_idx;
      sel_val = cmp_val;
    end
`ifdef HDC_SCHED_EXPLORE_EN
    if ((state_next == OUTPUT) && (explore_rnd < epsilon)) begin
      sel_idx      = IDX_W'(32'(explore_rnd) % 32'(LFSR_ACTIONS));
      sel_val      = $signed(acc_in[sel_idx]);
      sel_explored = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      vpipe    <= '0;
      ram_ptr  <= '0;
      best_idx <= '0;
      best_val <= '0;
`ifdef HDC_SCHED_EXPLORE_EN
      act_explored <= 1'b0;
`endif
    end else begin
      cnt <= (state_next != state) ? '0 : cnt + CNT_W'(1);

      if (state == CLEAR) vpipe <= '0;
      else                vpipe <= {vpipe[PIPE_DEPTH-1:0], (state == STREAM)};

      if (state == CLEAR)
        ram_ptr <= '0;
      else if ((state == STREAM) && (ram_ptr != PTR_LAST))
        ram_ptr <= ram_ptr + PTR_W'(1);

      if ((state == DRAIN) && (state_next == ARGMAX)) begin
        best_idx <= '0;
        best_val <= $signed(acc_in[0]);
`ifdef HDC_SCHED_EXPLORE_EN
        act_explored <= 1'b0;
`endif
      end else if (state == ARGMAX) begin
        best_idx <= sel_idx;
        best_val <= sel_val;
`ifdef HDC_SCHED_EXPLORE_EN
        act_explored <= sel_explored;
`endif
      end
    end
  end

`ifndef HDC_SCHED_EXPLORE_EN
  logic unused_explore;
  assign unused_explore = sel_explored;
`endif

endmodule

// File: tb/tb_hdc_action_scheduler.sv
// Directed bench for hdc_action_scheduler at default parameters: vector table plus
// hand-written hold, spurious-request, mid-pass reset and (optional) exploration sequences.
module tb_hdc_action_scheduler;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             proj_init;
  logic             act_init;
  logic [9:0]       ram_ptr;
  logic [2:0]       stage_en;
  logic             acc_clr;
  logic             acc_en;
  logic [3:0][21:0] acc_in;
  logic [1:0]       act_idx;
  logic [21:0]      act_value;
  logic             act_valid;
  logic             act_ready;
  logic             busy;
`ifdef HDC_SCHED_EXPLORE_EN
  logic [7:0]       explore_rnd;
  logic [7:0]       epsilon;
  logic             act_explored;
`endif

  hdc_action_scheduler #(
    .LFSR_ACTIONS(4), .ACC_WIDTH(22), .ADDR_WIDTH(11),
    .NUM_CHUNKS(64), .PIPE_DEPTH(3), .GEN_WARMUP(2)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .proj_init(proj_init), .act_init(act_init), .ram_ptr(ram_ptr),
    .stage_en(stage_en), .acc_clr(acc_clr), .acc_en(acc_en), .acc_in(acc_in),
`ifdef HDC_SCHED_EXPLORE_EN
    .explore_rnd(explore_rnd), .epsilon(epsilon), .act_explored(act_explored),
`endif
    .act_idx(act_idx), .act_value(act_value), .act_valid(act_valid),
    .act_ready(act_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Pass monitor: issue order, acc_en count and act_valid rises
  int   accen_cnt = 0;
  int   last_accen = -1;
  int   order_err = 0;
  int   exp_chunk = 0;
  int   first_issue = -1;
  int   valid_rises = 0;
  logic prev_valid = 1'b0;
  logic [9:0] prev_ptr = '0;

  always @(negedge clk) begin
    if (acc_clr) exp_chunk = 0;
    if (stage_en[0]) begin
      if (int'(prev_ptr) != exp_chunk) order_err++;
      if (exp_chunk == 0) first_issue = cyc - 1;
      exp_chunk++;
    end
    if (acc_en) begin
      accen_cnt++;
      last_accen = cyc;
    end
    if (act_valid && !prev_valid) valid_rises++;
    prev_valid = act_valid;
    prev_ptr   = ram_ptr;
  end

  typedef struct {
    int a0; int a1; int a2; int a3;
    int exp_idx;
    int exp_val;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input int a0, input int a1, input int a2, input int a3);
    acc_in[0] = 22'(a0);
    acc_in[1] = 22'(a1);
    acc_in[2] = 22'(a2);
    acc_in[3] = 22'(a3);
  endtask

  task automatic start_req(output int t);
    int n = 0;
    while (!req_ready && n < 100) begin
      tick;
      n++;
    end
    chk("req_ready_before_req", req_ready, 1);
    t = cyc;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int vc);
    int n = 0;
    while (!act_valid && n < 300) begin
      tick;
      n++;
    end
    chk("act_valid_seen", act_valid, 1);
    vc = act_valid ? cyc : -1;
  endtask

  task automatic handshake;
    act_ready = 1'b1;
    tick;
    act_ready = 1'b0;
    chk("req_ready_after_hs", req_ready, 1);
    chk("act_valid_after_hs", act_valid, 0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int t, vc, a0, e0;
    set_acc(v.a0, v.a1, v.a2, v.a3);
    a0 = accen_cnt;
    e0 = order_err;
    start_req(t);
    chk($sformatf("v%0d_acc_clr", k), acc_clr, 1);
    wait_valid(vc);
    chk($sformatf("v%0d_valid_cycle", k), vc, t + 75);
    chk($sformatf("v%0d_act_idx", k), act_idx, v.exp_idx);
    chk($sformatf("v%0d_act_value", k), longint'($signed(act_value)), v.exp_val);
    chk($sformatf("v%0d_acc_en_count", k), accen_cnt - a0, 64);
    chk($sformatf("v%0d_ptr_order_err", k), order_err - e0, 0);
    chk($sformatf("v%0d_first_issue", k), first_issue, t + 4);
    chk($sformatf("v%0d_last_acc_en", k), last_accen, t + 71);
`ifdef HDC_SCHED_EXPLORE_EN
    chk($sformatf("v%0d_explored", k), act_explored, 0);
`endif
    handshake;
  endtask

  initial begin
    int t, t2, vc, bad, rises0, n, a0;
    rst = 1'b1;
    req_valid = 1'b0;
    act_ready = 1'b0;
    set_acc(0, 0, 0, 0);
`ifdef HDC_SCHED_EXPLORE_EN
    explore_rnd = 8'h00;
    epsilon = 8'h00;
`endif
    vecs[0] = '{5, -3, 40, 12, 2, 40};
    vecs[1] = '{7, 7, -1, 7, 0, 7};
    vecs[2] = '{-10, -20, -5, -30, 2, -5};
    vecs[3] = '{0, 0, 0, 2097151, 3, 2097151};
    vecs[4] = '{-2097152, -2097152, -2097152, -2097152, 0, -2097152};

    repeat (3) tick;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_act_valid", act_valid, 0);
    chk("rst_acc_clr", acc_clr, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_stage_en", stage_en, 0);
    chk("rst_proj_init", proj_init | act_init, 0);
    chk("rst_ram_ptr", ram_ptr, 0);
    chk("rst_act_idx", act_idx, 0);
    chk("rst_act_value", act_value, 0);
    rst = 1'b0;
    repeat (2) tick;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Result held with act_ready low; inputs change underneath
    set_acc(5, -3, 40, 12);
    start_req(t);
    wait_valid(vc);
    set_acc(100, 200, 300, 400);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (!(act_valid && act_idx == 2'd2 && $signed(act_value) == 22'sd40)) bad++;
    end
    chk("hold_stable_errs", bad, 0);
    handshake;
    start_req(t2);
    chk("second_acc_clr", acc_clr, 1);
    chk("second_proj_init", proj_init, 1);
    tick;
    chk("second_ram_ptr_zero", ram_ptr, 0);
    chk("second_init_pulse", proj_init | act_init, 0);
    wait_valid(vc);
    chk("second_valid_cycle", vc, t2 + 75);
    chk("second_act_idx", act_idx, 3);
    chk("second_act_value", longint'($signed(act_value)), 400);
    handshake;

    // Requests during STREAM and DRAIN are ignored
    set_acc(7, 7, -1, 7);
    a0 = accen_cnt;
    start_req(t);
    while (cyc < t + 20) tick;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    while (cyc < t + 69) tick;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    wait_valid(vc);
    chk("spur_valid_cycle", vc, t + 75);
    chk("spur_act_idx", act_idx, 0);
    chk("spur_act_value", longint'($signed(act_value)), 7);
    chk("spur_acc_en_count", accen_cnt - a0, 64);
    handshake;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (busy) bad++;
    end
    chk("spur_no_extra_pass", bad, 0);

    // Reset in STREAM at ram_ptr=30
    set_acc(1, 2, 3, 4);
    rises0 = valid_rises;
    start_req(t);
    n = 0;
    while (!(busy && ram_ptr == 10'd30) && n < 200) begin
      tick;
      n++;
    end
    chk("midrst_ptr_reached", ram_ptr, 30);
    chk("midrst_ptr30_cycle", cyc, t + 34);
    rst = 1'b1;
    tick;
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_stage_en", stage_en, 0);
    chk("midrst_acc_en", acc_en, 0);
    chk("midrst_acc_clr", acc_clr, 0);
    chk("midrst_ram_ptr", ram_ptr, 0);
    rst = 1'b0;
    repeat (100) tick;
    chk("midrst_no_act_valid", valid_rises - rises0, 0);

    run_vec(vecs[0], 5);

`ifdef HDC_SCHED_EXPLORE_EN
    set_acc(5, -3, 40, 12);
    epsilon = 8'd128;
    explore_rnd = 8'h45;
    start_req(t);
    wait_valid(vc);
    chk("explore_valid_cycle", vc, t + 75);
    chk("explore_act_idx", act_idx, 1);
    chk("explore_act_value", longint'($signed(act_value)), -3);
    chk("explore_flag", act_explored, 1);
    handshake;
    explore_rnd = 8'hC0;
    start_req(t);
    wait_valid(vc);
    chk("greedy_act_idx", act_idx, 2);
    chk("greedy_act_value", longint'($signed(act_value)), 40);
    chk("greedy_flag", act_explored, 0);
    handshake;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
